// File: rtl/hint_pkg.sv
// Shared types, widths and constants for the hint reveal scheduler.
package hint_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RUN  = 3'd3,
        S_PICK = 3'd4
    } hint_state_e;

    localparam int MAX_LEN_DEF    = 8;
    localparam int ROUND_SECS_DEF = 60;

    localparam int WLEN_W = 4;
    localparam int LVL_W  = 3;
    localparam int IDX_W  = 3;
    localparam int SECS_W = 7;
    localparam int LFSR_W = 5;

    // Must stay different from the hint-level randomizer's seed.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b10011;

    // Seconds-left value at which hint k (1..3) is revealed.
    function automatic logic [SECS_W-1:0] th_secs(input int round_secs, input int k);
        return SECS_W'((round_secs * (4 - k)) / 4);
    endfunction

    // Hints for a round: level clamped to 3, capped so one letter always stays hidden.
    function automatic logic [1:0] calc_hints(input logic [WLEN_W-1:0] wl,
                                              input logic [LVL_W-1:0]  level);
        logic [1:0]        lvl;
        logic [WLEN_W-1:0] cap;
        lvl = (level > 3'd3) ? 2'd3 : level[1:0];
        cap = wl - 4'd1;
        if (wl <= 4'd1)
            calc_hints = 2'd0;
        else if ({2'b00, lvl} <= cap)
            calc_hints = lvl;
        else
            calc_hints = cap[1:0];
    endfunction

endpackage

// File: rtl/hint_reveal_scheduler_if.sv
// Signal bundle between the round controller and the hint reveal scheduler.
interface hint_reveal_scheduler_if
    import hint_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
);
    // Handshake: tick_1hz, round_start and round_abort are single-cycle pulses
    // with no backpressure; reveal_valid is a one-cycle qualifier for reveal_idx,
    // and round_done is a one-cycle pulse. hint_req is high for one cycle per round.
    logic                tick_1hz;
    logic                round_start;
    logic                round_abort;
    logic [WLEN_W-1:0]   word_len;
    logic [LVL_W-1:0]    hint_level;

    logic                hint_req;
    logic [MAX_LEN-1:0]  reveal_mask;
    logic                reveal_valid;
    logic [IDX_W-1:0]    reveal_idx;
    logic [SECS_W-1:0]   secs_left;
    logic                busy;
    logic                round_done;
    hint_state_e         state_dbg;

    modport master (
        output tick_1hz, round_start, round_abort, word_len, hint_level,
        input  hint_req, reveal_mask, reveal_valid, reveal_idx, secs_left,
               busy, round_done, state_dbg
    );

    modport slave (
        input  tick_1hz, round_start, round_abort, word_len, hint_level,
        output hint_req, reveal_mask, reveal_valid, reveal_idx, secs_left,
               busy, round_done, state_dbg
    );

endinterface

// File: rtl/hint_pos_lfsr.sv
// Free-running 5-bit Fibonacci LFSR (x^5 + x^3 + 1) used to pick reveal positions.
module hint_pos_lfsr
    import hint_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] q_o
);

    logic [LFSR_W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= LFSR_SEED;
        else
            q_q <= {q_q[3:0], q_q[4] ^ q_q[2]};
    end

    assign q_o = q_q;

endmodule

// File: rtl/hint_reveal_scheduler.sv
// Round timer that reveals up to three letters of the word at fixed time thresholds.
module hint_reveal_scheduler
    import hint_pkg::*;
#(
    parameter int MAX_LEN    = MAX_LEN_DEF,
    parameter int ROUND_SECS = ROUND_SECS_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    hint_reveal_scheduler_if.slave bus
);

    localparam logic [WLEN_W-1:0] WL_MAX    = WLEN_W'(MAX_LEN);
    localparam logic [SECS_W-1:0] SECS_INIT = SECS_W'(ROUND_SECS);
    localparam logic [SECS_W-1:0] TH1       = th_secs(ROUND_SECS, 1);
    localparam logic [SECS_W-1:0] TH2       = th_secs(ROUND_SECS, 2);
    localparam logic [SECS_W-1:0] TH3       = th_secs(ROUND_SECS, 3);

    hint_state_e        state_q, state_d;
    logic [MAX_LEN-1:0] mask_q, mask_d;
    logic [SECS_W-1:0]  secs_q, secs_d;
    logic [WLEN_W-1:0]  wl_q, wl_d;
    logic [1:0]         n_q, n_d;
    logic [IDX_W-1:0]   cand_q, cand_d;
    logic               pick_first_q, pick_first_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;

    logic [LFSR_W-1:0]  lfsr_val;
    logic [SECS_W-1:0]  secs_dec;
    logic [WLEN_W-1:0]  wl_in;
    logic               hit_th;
    logic               is_busy;

    hint_pos_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q_o   (lfsr_val)
    );

    assign is_busy  = (state_q != S_IDLE);
    assign secs_dec = secs_q - SECS_W'(1);
    assign wl_in    = (bus.word_len > WL_MAX) ? WL_MAX : bus.word_len;
    assign hit_th   = ((secs_dec == TH1) && (n_q >= 2'd1)) ||
                      ((secs_dec == TH2) && (n_q >= 2'd2)) ||
                      ((secs_dec == TH3) && (n_q == 2'd3));

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        secs_d       = secs_q;
        wl_d         = wl_q;
        n_d          = n_q;
        cand_d       = cand_q;
        pick_first_d = 1'b0;
        valid_d      = 1'b0;
        idx_d        = '0;
        done_d       = 1'b0;

        // Priority: abort, then (re)start, then end of round, then normal flow.
        if (bus.round_abort) begin
            state_d = S_IDLE;
            if (is_busy) begin
                mask_d = '0;
                secs_d = '0;
                n_d    = 2'd0;
            end
        end else if (bus.round_start) begin
            state_d = S_REQ;
            mask_d  = '0;
            secs_d  = SECS_INIT;
            wl_d    = wl_in;
            n_d     = 2'd0;
        end else if (is_busy && bus.tick_1hz && (secs_q == SECS_W'(1))) begin
            // Expiry wins over an in-flight PICK, which is dropped without a reveal.
            state_d = S_IDLE;
            secs_d  = '0;
            done_d  = 1'b1;
        end else begin
            if (is_busy && bus.tick_1hz)
                secs_d = secs_dec;
            case (state_q)
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    n_d     = calc_hints(wl_q, bus.hint_level);
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (bus.tick_1hz && hit_th) begin
                        state_d      = S_PICK;
                        pick_first_d = 1'b1;
                    end
                end
                S_PICK: begin
                    if (pick_first_q) begin
                        cand_d = IDX_W'(lfsr_val % {1'b0, wl_q});
                    end else if (mask_q[cand_q]) begin
                        cand_d = ({1'b0, cand_q} == (wl_q - 4'd1)) ? '0 : cand_q + IDX_W'(1);
                    end else begin
                        mask_d[cand_q] = 1'b1;
                        valid_d        = 1'b1;
                        idx_d          = cand_q;
                        state_d        = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            secs_q       <= '0;
            wl_q         <= '0;
            n_q          <= 2'd0;
            cand_q       <= '0;
            pick_first_q <= 1'b0;
            valid_q      <= 1'b0;
            idx_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            secs_q       <= secs_d;
            wl_q         <= wl_d;
            n_q          <= n_d;
            cand_q       <= cand_d;
            pick_first_q <= pick_first_d;
            valid_q      <= valid_d;
            idx_q        <= idx_d;
            done_q       <= done_d;
        end
    end

    assign bus.hint_req     = (state_q == S_REQ);
    assign bus.busy         = is_busy;
    assign bus.reveal_mask  = mask_q;
    assign bus.reveal_valid = valid_q;
    assign bus.reveal_idx   = idx_q;
    assign bus.secs_left    = secs_q;
    assign bus.round_done   = done_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_hint_reveal_scheduler.sv
// Directed + randomized self-checking bench for hint_reveal_scheduler.
module tb_hint_reveal_scheduler;
  import hint_pkg::*;

  localparam int ROUND = 60;
  localparam int MAXL  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hint_reveal_scheduler_if #(.MAX_LEN(MAXL)) bus ();

  hint_reveal_scheduler #(.MAX_LEN(MAXL), .ROUND_SECS(ROUND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];      // expected secs_left of each upcoming reveal
  logic [2:0] exp_idx_q[$];  // expected reveal positions when the LFSR is pinned
  logic [7:0] seen_mask;
  int wl_model;
  int exp_n;
  int rev_cnt;
  int done_cnt;
  int cyc_cnt = 0;
  int last_tick_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic on_reveal();
    logic [2:0] idx;
    idx = bus.reveal_idx;
    rev_cnt++;
    check("reveal_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) check("reveal_secs", bus.secs_left, exp_q.pop_front());
    if (exp_idx_q.size() != 0) check("reveal_idx", idx, exp_idx_q.pop_front());
    check("reveal_idx_range", int'(idx) < wl_model, 1);
    check("reveal_idx_fresh", seen_mask[idx], 0);
    check("reveal_mask_bit", bus.reveal_mask[idx], 1);
    check("reveal_latency", (cyc_cnt - last_tick_cyc) <= wl_model + 1, 1);
    seen_mask[idx] = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (bus.reveal_valid) on_reveal();
    if (bus.round_done) done_cnt++;
  endtask

  task automatic tick_once(input int gap);
    for (int i = 0; i < gap; i++) cyc();
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
    last_tick_cyc = cyc_cnt;
  endtask

  task automatic tick_until(input int target);
    int guard;
    guard = 0;
    while (bus.secs_left != 7'(target) && bus.busy && guard < ROUND + 2) begin
      tick_once($urandom_range(9, 13));
      guard++;
    end
    check("tick_until_reached", bus.secs_left, target);
  endtask

  task automatic start_round(input int wl_in, input int lvl_in);
    int wl, lvl;
    wl  = (wl_in > MAXL) ? MAXL : wl_in;
    lvl = (lvl_in > 3) ? 3 : lvl_in;
    exp_n = (wl <= 1) ? 0 : ((lvl < wl - 1) ? lvl : wl - 1);
    wl_model = wl;
    seen_mask = '0;
    rev_cnt = 0;
    done_cnt = 0;
    exp_q.delete();
    for (int k = 1; k <= exp_n; k++) exp_q.push_back(7'((ROUND * (4 - k)) / 4));
    bus.word_len = 4'(wl_in);
    bus.hint_level = 3'(lvl_in);
    bus.round_start = 1'b1;
    cyc();
    bus.round_start = 1'b0;
    check("start_hint_req", bus.hint_req, 1);
    check("start_busy", bus.busy, 1);
    check("start_secs", bus.secs_left, ROUND);
    check("start_mask_clear", bus.reveal_mask, 0);
    bus.word_len = 4'($urandom_range(0, 15));
    cyc();
    check("hint_req_one_cycle", bus.hint_req, 0);
    check("wait_busy", bus.busy, 1);
  endtask

  task automatic finish_round();
    int guard;
    guard = 0;
    while (bus.busy && guard < ROUND + 2) begin
      tick_once($urandom_range(9, 13));
      guard++;
    end
    check("done_pulse", bus.round_done, 1);
    check("done_secs", bus.secs_left, 0);
    check("done_idle", bus.busy, 0);
    check("reveals_pending", exp_q.size(), 0);
    check("reveal_count", rev_cnt, exp_n);
    check("mask_popcount", $countones(bus.reveal_mask), exp_n);
    check("mask_vs_reveals", bus.reveal_mask, seen_mask);
    cyc();
    check("done_one_cycle", bus.round_done, 0);
    check("done_count", done_cnt, 1);
    check("mask_held", bus.reveal_mask, seen_mask);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hint_req"}, bus.hint_req, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_mask"}, bus.reveal_mask, 0);
    check({tag, "_valid"}, bus.reveal_valid, 0);
    check({tag, "_idx"}, bus.reveal_idx, 0);
    check({tag, "_secs"}, bus.secs_left, 0);
    check({tag, "_done"}, bus.round_done, 0);
    check({tag, "_state"}, bus.state_dbg, S_IDLE);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.tick_1hz = 1'b0;
    bus.round_start = 1'b0;
    bus.round_abort = 1'b0;
    bus.word_len = '0;
    bus.hint_level = '0;
    seen_mask = '0;
    wl_model = 0;
    exp_n = 0;
    rev_cnt = 0;
    done_cnt = 0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three hints on a 6-letter word.
    start_round(6, 3);
    finish_round();

    // Short words.
    start_round(2, 3);
    finish_round();
    start_round(1, 3);
    finish_round();
    start_round(0, 2);
    finish_round();
    start_round(12, 3);
    finish_round();

    // Pinned LFSR: candidate 3 on a 4-letter word forces wrap 3 -> 0 -> 1.
    force dut.lfsr_val = 5'd3;
    start_round(4, 3);
    exp_idx_q = '{3'd3, 3'd0, 3'd1};
    finish_round();
    release dut.lfsr_val;
    check("collision_idx_used", exp_idx_q.size(), 0);

    // Abort in IDLE leaves the held mask alone.
    bus.round_abort = 1'b1;
    cyc();
    bus.round_abort = 1'b0;
    check("idle_abort_mask_held", bus.reveal_mask, seen_mask);
    check("idle_abort_busy", bus.busy, 0);

    // Abort at 20 s with mask 0b011.
    force dut.lfsr_val = 5'd0;
    start_round(6, 2);
    exp_idx_q = '{3'd0, 3'd1};
    tick_until(20);
    release dut.lfsr_val;
    check("abort_pre_mask", bus.reveal_mask, 8'b0000_0011);
    bus.round_abort = 1'b1;
    cyc();
    bus.round_abort = 1'b0;
    check_all_zero("abort");
    tick_once(4);
    tick_once(4);
    check("abort_secs_frozen", bus.secs_left, 0);
    check("abort_no_done", done_cnt, 0);

    // Restart while busy.
    start_round(5, 1);
    tick_once(10);
    tick_once(10);
    tick_once(10);
    check("restart_pre_secs", bus.secs_left, ROUND - 3);
    start_round(3, 3);
    finish_round();

    // Simultaneous start and abort, busy then idle.
    start_round(6, 1);
    cyc();
    bus.round_start = 1'b1;
    bus.round_abort = 1'b1;
    cyc();
    check_all_zero("start_abort_busy");
    cyc();
    check_all_zero("start_abort_idle");
    bus.round_start = 1'b0;
    bus.round_abort = 1'b0;
    cyc();
    check("start_abort_stays_idle", bus.busy, 0);

    // Reset asserted during PICK.
    start_round(8, 1);
    tick_until(45);
    check("pick_entered", bus.state_dbg, S_PICK);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("pick_reset");
    cyc();
    cyc();
    check("pick_reset_valid", bus.reveal_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    check("pick_reset_no_reveal", rev_cnt, 0);
    check("pick_reset_idle", bus.busy, 0);

    // Randomized rounds.
    for (int r = 0; r < 4; r++) begin
      start_round($urandom_range(0, 15), $urandom_range(0, 7));
      finish_round();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
